// File: rtl/frame_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// frame_pipeline_ctrl
// Frame-level sequencer for the CNN inference pipeline. For each accepted
// camera frame it clears the datapath, waits for the window buffer, the
// feature-map buffer and the matrix-multiply sums in turn, then picks the
// winning class (argmax of two signed sums) and holds it until acknowledged.
//
// Ports
//   clock, reset     : single clock, synchronous active-high reset
//   frame_start      : one-cycle pulse, start of a camera frame
//   buffer_rdy       : window buffer full (awaited in FILL)
//   fm_buffer_full   : feature map complete (awaited in CONV)
//   product_rdy      : class sums valid (awaited in CLASSIFY)
//   n0, n1           : signed class sums
//   result_ack       : consumer takes the held result
//   pipe_reset       : one-cycle datapath clear pulse
//   pipe_busy        : frame in flight
//   result_valid     : result_class/result_score valid (HOLD)
//   result_class     : winning class index
//   result_score     : winning signed sum
//   timeout_err      : sticky, a wait state ran out of time
//   frame_count      : frames classified, wraps
//   drop_count       : ignored frame_start pulses, saturates at 255
// -----------------------------------------------------------------------------
module frame_pipeline_ctrl #(
   parameter int OUT_W   = 32,
   parameter int TIMEOUT = 1048576
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    frame_start,
   input  logic                    buffer_rdy,
   input  logic                    fm_buffer_full,
   input  logic                    product_rdy,
   input  logic signed [OUT_W-1:0] n0,
   input  logic signed [OUT_W-1:0] n1,
   input  logic                    result_ack,
   output logic                    pipe_reset,
   output logic                    pipe_busy,
   output logic                    result_valid,
   output logic                    result_class,
   output logic signed [OUT_W-1:0] result_score,
   output logic                    timeout_err,
   output logic [15:0]             frame_count,
   output logic [7:0]              drop_count
);

   localparam int             TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FILL, CONV, CLASSIFY, HOLD} state_t;

   state_t                  state_q, state_d;
   logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
   logic                    pipe_reset_q, pipe_reset_d;
   logic                    pipe_busy_q, pipe_busy_d;
   logic                    result_valid_q, result_valid_d;
   logic                    result_class_q, result_class_d;
   logic signed [OUT_W-1:0] result_score_q, result_score_d;
   logic                    timeout_err_q, timeout_err_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic [7:0]              drop_count_q, drop_count_d;
   logic                    timed_out;
   logic                    drop;
   logic                    n1_wins;

   assign timed_out = (tmo_cnt_q == TO_LAST);
   // Strict compare: a tie goes to class 0.
   assign n1_wins   = (n1 > n0);

   always_comb begin
      state_d        = state_q;
      tmo_cnt_d      = '0;
      timeout_err_d  = timeout_err_q;
      frame_count_d  = frame_count_q;
      drop_count_d   = drop_count_q;
      result_class_d = result_class_q;
      result_score_d = result_score_q;
      drop           = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start) state_d = CLEAR;
         end
         CLEAR: begin
            drop    = frame_start;
            state_d = FILL;
         end
         // In each wait state the awaited input beats a same-cycle timeout.
         FILL: begin
            drop = frame_start;
            if (buffer_rdy) begin
               state_d = CONV;
            end else if (timed_out) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         CONV: begin
            drop = frame_start;
            if (fm_buffer_full) begin
               state_d = CLASSIFY;
            end else if (timed_out) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         CLASSIFY: begin
            drop = frame_start;
            if (product_rdy) begin
               state_d        = HOLD;
               result_class_d = n1_wins;
               result_score_d = n1_wins ? n1 : n0;
               frame_count_d  = frame_count_q + 16'd1;
            end else if (timed_out) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         HOLD: begin
            // A new frame may start in the same cycle the result is taken.
            if (result_ack) state_d = frame_start ? CLEAR : IDLE;
            else            drop    = frame_start;
         end
         default: state_d = IDLE;
      endcase

      if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;

      // Status outputs are registered copies of the next-state decode, so
      // they line up with the state they describe.
      pipe_reset_d   = (state_d == CLEAR);
      pipe_busy_d    = (state_d == CLEAR) || (state_d == FILL) ||
                       (state_d == CONV)  || (state_d == CLASSIFY);
      result_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         tmo_cnt_q      <= '0;
         pipe_reset_q   <= 1'b0;
         pipe_busy_q    <= 1'b0;
         result_valid_q <= 1'b0;
         result_class_q <= 1'b0;
         result_score_q <= '0;
         timeout_err_q  <= 1'b0;
         frame_count_q  <= '0;
         drop_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         tmo_cnt_q      <= tmo_cnt_d;
         pipe_reset_q   <= pipe_reset_d;
         pipe_busy_q    <= pipe_busy_d;
         result_valid_q <= result_valid_d;
         result_class_q <= result_class_d;
         result_score_q <= result_score_d;
         timeout_err_q  <= timeout_err_d;
         frame_count_q  <= frame_count_d;
         drop_count_q   <= drop_count_d;
      end
   end

   assign pipe_reset   = pipe_reset_q;
   assign pipe_busy    = pipe_busy_q;
   assign result_valid = result_valid_q;
   assign result_class = result_class_q;
   assign result_score = result_score_q;
   assign timeout_err  = timeout_err_q;
   assign frame_count  = frame_count_q;
   assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_frame_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_pipeline_ctrl
// Self-checking bench for frame_pipeline_ctrl (TIMEOUT=16). A small model
// tracks expected frame count, drop count, error flag and the argmax result;
// scenario tasks drive frames with random wait lengths and random noise on
// inputs that must be ignored.
// -----------------------------------------------------------------------------
module tb_frame_pipeline_ctrl;

   localparam int OW = 32;
   localparam int TO = 16;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 frame_start = 1'b0;
   logic                 buffer_rdy = 1'b0;
   logic                 fm_buffer_full = 1'b0;
   logic                 product_rdy = 1'b0;
   logic                 result_ack = 1'b0;
   logic signed [OW-1:0] n0 = '0;
   logic signed [OW-1:0] n1 = '0;
   logic                 pipe_reset, pipe_busy, result_valid, result_class;
   logic signed [OW-1:0] result_score;
   logic                 timeout_err;
   logic [15:0]          frame_count;
   logic [7:0]           drop_count;

   int                   n_pass = 0;
   int                   n_total = 0;

   // Reference model state
   int                   exp_frames = 0;
   int                   exp_drops = 0;
   logic                 exp_err = 1'b0;
   logic                 exp_class = 1'b0;
   logic signed [OW-1:0] exp_score = '0;

   frame_pipeline_ctrl #(.OUT_W(OW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .buffer_rdy(buffer_rdy), .fm_buffer_full(fm_buffer_full),
      .product_rdy(product_rdy), .n0(n0), .n1(n1), .result_ack(result_ack),
      .pipe_reset(pipe_reset), .pipe_busy(pipe_busy), .result_valid(result_valid),
      .result_class(result_class), .result_score(result_score),
      .timeout_err(timeout_err), .frame_count(frame_count), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fs(input int mode);
      if (mode == 2)      frame_start = 1'b1;
      else if (mode == 1) frame_start = 1'($urandom_range(0, 1));
      else                frame_start = 1'b0;
   endtask

   // A frame_start seen while the frame is busy (or unacknowledged) is a drop.
   task automatic model_drop();
      if (frame_start && exp_drops < 255) exp_drops++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      frame_start = 0; buffer_rdy = 0; fm_buffer_full = 0; product_rdy = 0; result_ack = 0;
      tick();
      reset = 1'b0;
      exp_frames = 0; exp_drops = 0; exp_err = 0; exp_class = 0; exp_score = '0;
   endtask

   // which: 0 = FILL (buffer_rdy), 1 = CONV (fm_buffer_full), 2 = CLASSIFY (product_rdy).
   // w cycles without the awaited input, then one cycle with it.
   task automatic wait_phase(input int which, input int w, input int mode,
                             input logic signed [OW-1:0] a, input logic signed [OW-1:0] b);
      logic [2:0] exp_st;
      for (int i = 0; i <= w; i++) begin
         set_fs(mode);
         model_drop();
         buffer_rdy     = 1'($urandom_range(0, 1));
         fm_buffer_full = 1'($urandom_range(0, 1));
         product_rdy    = 1'($urandom_range(0, 1));
         n0 = $signed($urandom);
         n1 = $signed($urandom);
         case (which)
            0: buffer_rdy = (i == w);
            1: fm_buffer_full = (i == w);
            default: begin
               product_rdy = (i == w);
               if (i == w) begin
                  n0 = a;
                  n1 = b;
                  exp_frames++;
                  exp_class = (b > a);
                  exp_score = (b > a) ? b : a;
               end
            end
         endcase
         tick();
         exp_st = (which == 2 && i == w) ? 3'b001 : 3'b010;
         n_total++;
         if ({pipe_reset, pipe_busy, result_valid} !== exp_st) begin
            $display("FAIL phase%0d_status cyc=%0d got=%b want=%b", which, i,
                     {pipe_reset, pipe_busy, result_valid}, exp_st);
         end else n_pass++;
      end
      frame_start = 0; buffer_rdy = 0; fm_buffer_full = 0; product_rdy = 0;
      n_total++;
      if (drop_count !== 8'(exp_drops) || timeout_err !== exp_err) begin
         $display("FAIL phase%0d_counts drop=%0d err=%b want drop=%0d err=%b", which,
                  drop_count, timeout_err, exp_drops, exp_err);
      end else n_pass++;
      if (which == 2) begin
         n_total++;
         if (result_class !== exp_class || result_score !== exp_score ||
             frame_count !== 16'(exp_frames)) begin
            $display("FAIL latch got class=%b score=%0d frames=%0d want class=%b score=%0d frames=%0d",
                     result_class, result_score, frame_count, exp_class, exp_score, exp_frames);
         end else n_pass++;
      end
   endtask

   task automatic do_frame(input int fill_w, input int conv_w, input int cls_w,
                           input logic signed [OW-1:0] a, input logic signed [OW-1:0] b,
                           input int mode, input int hold_w, input bit in_clear, input bit b2b);
      if (!in_clear) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         n_total++;
         if ({pipe_reset, pipe_busy, result_valid} !== 3'b110) begin
            $display("FAIL clear_status got=%b want=110", {pipe_reset, pipe_busy, result_valid});
         end else n_pass++;
      end
      // CLEAR cycle; the next edge must land in FILL.
      set_fs(mode);
      model_drop();
      tick();
      n_total++;
      if ({pipe_reset, pipe_busy, result_valid} !== 3'b010) begin
         $display("FAIL fill_entry got=%b want=010", {pipe_reset, pipe_busy, result_valid});
      end else n_pass++;
      wait_phase(0, fill_w, mode, a, b);
      wait_phase(1, conv_w, mode, a, b);
      wait_phase(2, cls_w, mode, a, b);
      for (int i = 0; i < hold_w; i++) begin
         set_fs(mode);
         model_drop();
         result_ack     = 1'b0;
         buffer_rdy     = 1'($urandom_range(0, 1));
         fm_buffer_full = 1'($urandom_range(0, 1));
         product_rdy    = 1'($urandom_range(0, 1));
         n0 = $signed($urandom);
         n1 = $signed($urandom);
         tick();
         n_total++;
         if (result_valid !== 1'b1 || pipe_busy !== 1'b0 || result_class !== exp_class ||
             result_score !== exp_score || drop_count !== 8'(exp_drops)) begin
            $display("FAIL hold_stable cyc=%0d valid=%b busy=%b class=%b score=%0d drop=%0d want class=%b score=%0d drop=%0d",
                     i, result_valid, pipe_busy, result_class, result_score, drop_count,
                     exp_class, exp_score, exp_drops);
         end else n_pass++;
      end
      buffer_rdy = 0; fm_buffer_full = 0; product_rdy = 0;
      frame_start = b2b;
      result_ack  = 1'b1;
      tick();
      frame_start = 1'b0;
      result_ack  = 1'b0;
      n_total++;
      if ({pipe_reset, pipe_busy, result_valid} !== (b2b ? 3'b110 : 3'b000) ||
          result_class !== exp_class || result_score !== exp_score ||
          drop_count !== 8'(exp_drops)) begin
         $display("FAIL ack_exit b2b=%0d status=%b class=%b score=%0d drop=%0d want class=%b score=%0d drop=%0d",
                  b2b, {pipe_reset, pipe_busy, result_valid}, result_class, result_score,
                  drop_count, exp_class, exp_score, exp_drops);
      end else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         frame_start = 1'($urandom_range(0, 1));
         buffer_rdy = 1'($urandom_range(0, 1));
         product_rdy = 1'($urandom_range(0, 1));
         tick();
      end
      n_total++;
      if ({pipe_reset, pipe_busy, result_valid, result_class, result_score, timeout_err,
           frame_count, drop_count} !== '0) begin
         $display("FAIL reset_values status=%b score=%0d err=%b frames=%0d drops=%0d want all 0",
                  {pipe_reset, pipe_busy, result_valid, result_class}, result_score,
                  timeout_err, frame_count, drop_count);
      end else n_pass++;
      do_reset();
      tick();
      n_total++;
      if ({pipe_reset, pipe_busy, result_valid, timeout_err, frame_count, drop_count} !== '0) begin
         $display("FAIL idle_after_reset status=%b frames=%0d drops=%0d want all 0",
                  {pipe_reset, pipe_busy, result_valid, timeout_err}, frame_count, drop_count);
      end else n_pass++;
   endtask

   task automatic test_nominal();
      // buffer_rdy 10 cycles after frame_start, fm_buffer_full 20 cycles after.
      do_frame(8, 9, 2, 32'sd5, -32'sd3, 0, 2, 1'b0, 1'b0);
      n_total++;
      if (result_class !== 1'b0 || result_score !== 32'sd5 || frame_count !== 16'd1) begin
         $display("FAIL nominal class=%b score=%0d frames=%0d want 0 5 1",
                  result_class, result_score, frame_count);
      end else n_pass++;
   endtask

   task automatic test_argmax();
      do_frame(1, 1, 0, -32'sd7, -32'sd7, 0, 0, 1'b0, 1'b0);
      n_total++;
      if (result_class !== 1'b0 || result_score !== -32'sd7) begin
         $display("FAIL tie class=%b score=%0d want 0 -7", result_class, result_score);
      end else n_pass++;
      do_frame(0, 2, 1, -32'sd8, -32'sd2, 0, 1, 1'b0, 1'b0);
      n_total++;
      if (result_class !== 1'b1 || result_score !== -32'sd2) begin
         $display("FAIL neg class=%b score=%0d want 1 -2", result_class, result_score);
      end else n_pass++;
   endtask

   task automatic test_drops_back_to_back();
      int d0;
      frame_start = 1; tick(); frame_start = 0;
      tick();
      buffer_rdy = 1; tick(); buffer_rdy = 0;
      d0 = exp_drops;
      for (int i = 0; i < 3; i++) begin
         frame_start = 1; model_drop(); tick(); frame_start = 0; tick();
         n_total++;
         if ({pipe_reset, pipe_busy, result_valid} !== 3'b010) begin
            $display("FAIL conv_drop_state got=%b want=010", {pipe_reset, pipe_busy, result_valid});
         end else n_pass++;
      end
      n_total++;
      if (drop_count !== 8'(d0 + 3)) begin
         $display("FAIL conv_drops got=%0d want=%0d", drop_count, d0 + 3);
      end else n_pass++;
      fm_buffer_full = 1; tick(); fm_buffer_full = 0;
      n0 = 32'sd11; n1 = 32'sd12; product_rdy = 1;
      exp_frames++; exp_class = 1'b1; exp_score = 32'sd12;
      tick(); product_rdy = 0;
      n_total++;
      if (result_valid !== 1'b1 || result_score !== 32'sd12 || frame_count !== 16'(exp_frames)) begin
         $display("FAIL b2b_hold valid=%b score=%0d frames=%0d want 1 12 %0d",
                  result_valid, result_score, frame_count, exp_frames);
      end else n_pass++;
      result_ack = 1; frame_start = 1; tick(); result_ack = 0; frame_start = 0;
      n_total++;
      if (pipe_reset !== 1'b1 || drop_count !== 8'(d0 + 3)) begin
         $display("FAIL b2b_restart pipe_reset=%b drop=%0d want 1 %0d", pipe_reset, drop_count, d0 + 3);
      end else n_pass++;
      do_frame(2, 2, 2, 32'sd1, 32'sd0, 0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      bit in_clear = 1'b0;
      bit b2b;
      for (int f = 0; f < 8; f++) begin
         b2b = (f == 7) ? 1'b0 : 1'($urandom_range(0, 1));
         do_frame(int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                  int'($urandom_range(0, 14)), $signed($urandom), $signed($urandom),
                  1, int'($urandom_range(0, 3)), in_clear, b2b);
         in_clear = b2b;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      do_frame(0, 0, 0, 32'sd9, 32'sd1, 0, 0, 1'b0, 1'b0);
      frame_start = 1; tick(); frame_start = 0;
      tick();
      buffer_rdy = 1; tick(); buffer_rdy = 0;
      // Now in the first CONV cycle; fm_buffer_full withheld.
      for (int i = 1; i < TO; i++) tick();
      n_total++;
      if (pipe_busy !== 1'b1 || timeout_err !== 1'b0) begin
         $display("FAIL timeout_early busy=%b err=%b want 1 0", pipe_busy, timeout_err);
      end else n_pass++;
      tick();
      exp_err = 1'b1;
      n_total++;
      if (pipe_busy !== 1'b0 || result_valid !== 1'b0 || timeout_err !== 1'b1 ||
          frame_count !== 16'd1 || result_score !== 32'sd9 || result_class !== 1'b0) begin
         $display("FAIL timeout_fire busy=%b valid=%b err=%b frames=%0d score=%0d want 0 0 1 1 9",
                  pipe_busy, result_valid, timeout_err, frame_count, result_score);
      end else n_pass++;
      tick(); tick();
      n_total++;
      if (timeout_err !== 1'b1 || pipe_busy !== 1'b0) begin
         $display("FAIL timeout_sticky err=%b busy=%b want 1 0", timeout_err, pipe_busy);
      end else n_pass++;
      do_reset();
      // fm_buffer_full arrives on the 16th CONV cycle: awaited input wins.
      do_frame(3, TO - 1, 2, -32'sd4, 32'sd6, 0, 1, 1'b0, 1'b0);
      n_total++;
      if (timeout_err !== 1'b0 || frame_count !== 16'd1) begin
         $display("FAIL timeout_edge err=%b frames=%0d want 0 1", timeout_err, frame_count);
      end else n_pass++;
   endtask

   task automatic test_reset_mid();
      frame_start = 1; tick(); frame_start = 0;
      tick();
      buffer_rdy = 1; tick(); buffer_rdy = 0;
      fm_buffer_full = 1; tick(); fm_buffer_full = 0;
      n0 = 32'sd100; n1 = 32'sd200; product_rdy = 1; frame_start = 1;
      reset = 1;
      tick();
      n_total++;
      if ({pipe_reset, pipe_busy, result_valid, result_class, result_score, timeout_err,
           frame_count, drop_count} !== '0) begin
         $display("FAIL reset_mid status=%b score=%0d frames=%0d drops=%0d want all 0",
                  {pipe_reset, pipe_busy, result_valid, result_class}, result_score,
                  frame_count, drop_count);
      end else n_pass++;
      reset = 0; product_rdy = 0; frame_start = 0;
      exp_frames = 0; exp_drops = 0; exp_err = 0; exp_class = 0; exp_score = '0;
      tick();
      n_total++;
      if ({pipe_busy, result_valid, result_score, frame_count} !== '0) begin
         $display("FAIL reset_mid_idle busy=%b valid=%b score=%0d frames=%0d want all 0",
                  pipe_busy, result_valid, result_score, frame_count);
      end else n_pass++;
   endtask

   task automatic test_drop_sat();
      do_reset();
      for (int f = 0; f < 7; f++) do_frame(14, 14, 14, 32'sd3, 32'sd4, 2, 2, 1'b0, 1'b0);
      n_total++;
      if (drop_count !== 8'd255) begin
         $display("FAIL drop_saturate got=%0d want=255", drop_count);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_argmax();
      test_drops_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid();
      test_drop_sat();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
